// File: rtl/pixel_word_packer.sv
`timescale 1ns/1ps
// Packs four 8-bit pixels into a 32-bit line-buffer word with column/line addressing and frame tracking.
// Latency: save_data strobes one cycle after the 4th pixel of a word is accepted.
// Backpressure: none; every pixel_valid cycle is consumed. Optional LINE_ERR_EN adds line_end resync.
module pixel_word_packer #(
  parameter int LINE_WIDTH  = 512,
  parameter int FRAME_LINES = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  input  logic        line_end,
  output logic [31:0] datain,
  output logic [8:0]  address,
  output logic [8:0]  vertical_count,
  output logic        save_data,
  output logic        frame_done,
  output logic        overflow,
  output logic        line_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [8:0] LAST_COL  = 9'(LINE_WIDTH - 1);
  localparam logic [8:0] LAST_LINE = 9'(FRAME_LINES - 1);

  state_t      state_q, state_d;
  logic [8:0]  col_q, col_d;
  logic [8:0]  line_q, line_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] datain_q, datain_d;
  logic [8:0]  address_q, address_d;
  logic [8:0]  vcount_q, vcount_d;
  logic        save_q, save_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        lerr_q, lerr_d;
  logic        resync;

  // A short/long line resyncs only when the feature is built in; otherwise line_end is dropped.
`ifdef LINE_ERR_EN
  assign resync = (state_q == S_ACTIVE) && line_end && (col_q != 9'd0);
`else
  logic unused_line_end;
  assign unused_line_end = line_end;
  assign resync = 1'b0;
`endif

  // Next-state, packing and strobe generation; frame_start overrides everything else.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    shift_d   = shift_q;
    datain_d  = datain_q;
    address_d = address_q;
    vcount_d  = vcount_q;
    save_d    = 1'b0;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    lerr_d    = lerr_q;

    if (frame_start) begin
      // New frame; a coincident pixel becomes column 0 of it.
      state_d = S_ACTIVE;
      col_d   = 9'd0;
      line_d  = 9'd0;
      shift_d = 24'd0;
      if (pixel_valid) begin
        shift_d[7:0] = pixel_in;
        col_d        = 9'd1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Pixels outside a frame are ignored.
        end

        S_ACTIVE: begin
          if (resync) begin
            // Resync wins over a coincident pixel: partial word and that pixel are dropped.
            lerr_d  = 1'b1;
            shift_d = 24'd0;
            col_d   = 9'd0;
            line_d  = line_q + 9'd1;
            if (line_q == LAST_LINE) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else if (pixel_valid) begin
            col_d = col_q + 9'd1;
            case (col_q[1:0])
              2'd0: shift_d[7:0]   = pixel_in;
              2'd1: shift_d[15:8]  = pixel_in;
              2'd2: shift_d[23:16] = pixel_in;
              default: begin
                // Lane 3 completes the word; the strobe carries the line it was captured on.
                save_d    = 1'b1;
                datain_d  = {pixel_in, shift_q};
                address_d = {col_q[8:2], 2'b00};
                vcount_d  = line_q;
                shift_d   = 24'd0;
              end
            endcase
            if (col_q == LAST_COL) begin
              col_d  = 9'd0;
              line_d = line_q + 9'd1;
              if (line_q == LAST_LINE) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          if (pixel_valid) begin
            ovf_d = 1'b1;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; overflow/line_err are cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      col_q     <= 9'd0;
      line_q    <= 9'd0;
      shift_q   <= 24'd0;
      datain_q  <= 32'd0;
      address_q <= 9'd0;
      vcount_q  <= 9'd0;
      save_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      lerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      line_q    <= line_d;
      shift_q   <= shift_d;
      datain_q  <= datain_d;
      address_q <= address_d;
      vcount_q  <= vcount_d;
      save_q    <= save_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      lerr_q    <= lerr_d;
    end
  end

  assign datain         = datain_q;
  assign address        = address_q;
  assign vertical_count = vcount_q;
  assign save_data      = save_q;
  assign frame_done     = done_q;
  assign overflow       = ovf_q;
  assign line_err       = lerr_q;

endmodule
